// File: rtl/motion_zone_bbox_if.sv
// Pixel-stream inputs and per-frame result outputs of the motion bounding-box extractor.
interface motion_zone_bbox_if #(
    parameter int N_ZONES = 4,
    parameter int XW      = 10,
    parameter int YW      = 10,
    parameter int CW      = 16
);
    logic                    per_frame_vsync;
    logic                    per_frame_href;
    logic                    per_frame_clken;
    logic                    per_img_bit;
    logic                    frame_done;
    logic [N_ZONES-1:0]      zone_valid;
    logic [N_ZONES*XW-1:0]   zone_xmin;
    logic [N_ZONES*XW-1:0]   zone_xmax;
    logic [N_ZONES*YW-1:0]   zone_ymin;
    logic [N_ZONES*YW-1:0]   zone_ymax;
    logic [N_ZONES*CW-1:0]   zone_count;
    logic                    all_valid;
    logic [XW-1:0]           all_xmin;
    logic [XW-1:0]           all_xmax;
    logic [YW-1:0]           all_ymin;
    logic [YW-1:0]           all_ymax;

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
        output frame_done, zone_valid, zone_xmin, zone_xmax, zone_ymin, zone_ymax,
               zone_count, all_valid, all_xmin, all_xmax, all_ymin, all_ymax
    );

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
        input  frame_done, zone_valid, zone_xmin, zone_xmax, zone_ymin, zone_ymax,
               zone_count, all_valid, all_xmin, all_xmax, all_ymin, all_ymax
    );
endinterface

// File: rtl/motion_zone_bbox.sv
// Multi-zone bounding-box extractor for a binary motion mask. Each frame is split
// into N_ZONES column zones; per zone the min/max X/Y and set-pixel count are
// accumulated, and a union box over the valid zones is latched once per frame.
module motion_zone_bbox #(
    parameter int IMG_HDISP  = 640,
    parameter int IMG_VDISP  = 480,
    parameter int N_ZONES    = 4,
    parameter int XW         = 10,
    parameter int YW         = 10,
    parameter int CW         = 16,
    parameter int MIN_PIXELS = 16
) (
    input  logic clk,
    input  logic rst_n,
    motion_zone_bbox_if.slave bus
);
    localparam int ZONE_W = IMG_HDISP / N_ZONES;
    localparam int ZCW    = (ZONE_W > 1) ? $clog2(ZONE_W) : 1;
    localparam int ZIW    = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
    localparam logic [XW:0]     H_LIM   = (XW+1)'(IMG_HDISP);
    localparam logic [YW:0]     V_LIM   = (YW+1)'(IMG_VDISP);
    localparam logic [ZCW-1:0]  ZW_M1   = ZCW'(ZONE_W - 1);
    localparam logic [ZIW-1:0]  Z_LAST  = ZIW'(N_ZONES - 1);
    localparam logic [CW-1:0]   CNT_MAX = {CW{1'b1}};
    localparam logic [31:0]     MIN_L   = 32'(MIN_PIXELS);

    logic              vsync_q, vsync_d, href_q, href_d, armed_q, armed_d, done_q, done_d;
    logic [XW:0]       x_q, x_d;
    logic [YW:0]       y_q, y_d;
    logic [ZCW-1:0]    zc_q, zc_d;
    logic [ZIW-1:0]    zi_q, zi_d;
    // running accumulators
    logic [CW-1:0]     cnt_q [N_ZONES], cnt_d [N_ZONES];
    logic [XW-1:0]     axmin_q [N_ZONES], axmin_d [N_ZONES], axmax_q [N_ZONES], axmax_d [N_ZONES];
    logic [YW-1:0]     aymin_q [N_ZONES], aymin_d [N_ZONES], aymax_q [N_ZONES], aymax_d [N_ZONES];
    // latched results
    logic [N_ZONES-1:0] vld_q, vld_d;
    logic [CW-1:0]     ocnt_q [N_ZONES], ocnt_d [N_ZONES];
    logic [XW-1:0]     oxmin_q [N_ZONES], oxmin_d [N_ZONES], oxmax_q [N_ZONES], oxmax_d [N_ZONES];
    logic [YW-1:0]     oymin_q [N_ZONES], oymin_d [N_ZONES], oymax_q [N_ZONES], oymax_d [N_ZONES];
    logic              uvld_q, uvld_d;
    logic [XW-1:0]     uxmin_q, uxmin_d, uxmax_q, uxmax_d;
    logic [YW-1:0]     uymin_q, uymin_d, uymax_q, uymax_d;

    logic [N_ZONES-1:0] zv;
    logic              u_any;
    logic [XW-1:0]     u_xmin, u_xmax;
    logic [YW-1:0]     u_ymin, u_ymax;
    logic              vs_rise, href_fall, step, accept;

    // Zone validity and union box over valid zones, straight from the accumulators.
    always_comb begin
        zv     = '0;
        u_any  = 1'b0;
        u_xmin = '0;
        u_xmax = '0;
        u_ymin = '0;
        u_ymax = '0;
        for (int k = 0; k < N_ZONES; k++) begin
            zv[k] = ({{(32-CW){1'b0}}, cnt_q[k]} >= MIN_L);
            if (zv[k]) begin
                if (!u_any) begin
                    u_xmin = axmin_q[k];
                    u_xmax = axmax_q[k];
                    u_ymin = aymin_q[k];
                    u_ymax = aymax_q[k];
                end else begin
                    if (axmin_q[k] < u_xmin) u_xmin = axmin_q[k];
                    if (axmax_q[k] > u_xmax) u_xmax = axmax_q[k];
                    if (aymin_q[k] < u_ymin) u_ymin = aymin_q[k];
                    if (aymax_q[k] > u_ymax) u_ymax = aymax_q[k];
                end
                u_any = 1'b1;
            end
        end
    end

    // Position counters, per-zone accumulation and frame-boundary latch.
    always_comb begin
        vsync_d = bus.per_frame_vsync;
        href_d  = bus.per_frame_href;
        armed_d = armed_q;
        done_d  = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        zc_d    = zc_q;
        zi_d    = zi_q;
        cnt_d   = cnt_q;
        axmin_d = axmin_q;
        axmax_d = axmax_q;
        aymin_d = aymin_q;
        aymax_d = aymax_q;
        vld_d   = vld_q;
        ocnt_d  = ocnt_q;
        oxmin_d = oxmin_q;
        oxmax_d = oxmax_q;
        oymin_d = oymin_q;
        oymax_d = oymax_q;
        uvld_d  = uvld_q;
        uxmin_d = uxmin_q;
        uxmax_d = uxmax_q;
        uymin_d = uymin_q;
        uymax_d = uymax_q;

        vs_rise   = bus.per_frame_vsync & ~vsync_q;
        href_fall = href_q & ~bus.per_frame_href;
        step      = bus.per_frame_href & bus.per_frame_clken & (x_q < H_LIM);
        accept    = step & ~bus.per_frame_vsync & (y_q < V_LIM);

        // x and zone tracking restart at every line end and throughout vsync
        if (href_fall || bus.per_frame_vsync) begin
            x_d  = '0;
            zc_d = '0;
            zi_d = '0;
        end else if (step) begin
            x_d = x_q + 1'b1;
            if (zc_q == ZW_M1) begin
                zc_d = '0;
                if (zi_q != Z_LAST) zi_d = zi_q + 1'b1;
            end else begin
                zc_d = zc_q + 1'b1;
            end
        end

        if (bus.per_frame_vsync) y_d = '0;
        else if (href_fall && (y_q < V_LIM)) y_d = y_q + 1'b1;

        for (int k = 0; k < N_ZONES; k++) begin
            if (accept && bus.per_img_bit && (zi_q == ZIW'(k))) begin
                if (cnt_q[k] == '0) begin
                    axmin_d[k] = x_q[XW-1:0];
                    axmax_d[k] = x_q[XW-1:0];
                    aymin_d[k] = y_q[YW-1:0];
                    aymax_d[k] = y_q[YW-1:0];
                end else begin
                    if (x_q[XW-1:0] < axmin_q[k]) axmin_d[k] = x_q[XW-1:0];
                    if (x_q[XW-1:0] > axmax_q[k]) axmax_d[k] = x_q[XW-1:0];
                    if (y_q[YW-1:0] < aymin_q[k]) aymin_d[k] = y_q[YW-1:0];
                    if (y_q[YW-1:0] > aymax_q[k]) aymax_d[k] = y_q[YW-1:0];
                end
                if (cnt_q[k] != CNT_MAX) cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end

        // the first boundary after reset only arms, discarding the partial frame
        if (vs_rise) begin
            if (armed_q) begin
                done_d = 1'b1;
                vld_d  = zv;
                for (int k = 0; k < N_ZONES; k++) begin
                    ocnt_d[k]  = cnt_q[k];
                    oxmin_d[k] = zv[k] ? axmin_q[k] : '0;
                    oxmax_d[k] = zv[k] ? axmax_q[k] : '0;
                    oymin_d[k] = zv[k] ? aymin_q[k] : '0;
                    oymax_d[k] = zv[k] ? aymax_q[k] : '0;
                end
                uvld_d  = u_any;
                uxmin_d = u_xmin;
                uxmax_d = u_xmax;
                uymin_d = u_ymin;
                uymax_d = u_ymax;
            end
            armed_d = 1'b1;
            for (int k = 0; k < N_ZONES; k++) begin
                cnt_d[k]   = '0;
                axmin_d[k] = '0;
                axmax_d[k] = '0;
                aymin_d[k] = '0;
                aymax_d[k] = '0;
            end
        end
    end

    // State registers; reset clears everything and disarms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            zc_q    <= '0;
            zi_q    <= '0;
            vld_q   <= '0;
            uvld_q  <= 1'b0;
            uxmin_q <= '0;
            uxmax_q <= '0;
            uymin_q <= '0;
            uymax_q <= '0;
            for (int k = 0; k < N_ZONES; k++) begin
                cnt_q[k]   <= '0;
                axmin_q[k] <= '0;
                axmax_q[k] <= '0;
                aymin_q[k] <= '0;
                aymax_q[k] <= '0;
                ocnt_q[k]  <= '0;
                oxmin_q[k] <= '0;
                oxmax_q[k] <= '0;
                oymin_q[k] <= '0;
                oymax_q[k] <= '0;
            end
        end else begin
            vsync_q <= vsync_d;
            href_q  <= href_d;
            armed_q <= armed_d;
            done_q  <= done_d;
            x_q     <= x_d;
            y_q     <= y_d;
            zc_q    <= zc_d;
            zi_q    <= zi_d;
            cnt_q   <= cnt_d;
            axmin_q <= axmin_d;
            axmax_q <= axmax_d;
            aymin_q <= aymin_d;
            aymax_q <= aymax_d;
            vld_q   <= vld_d;
            ocnt_q  <= ocnt_d;
            oxmin_q <= oxmin_d;
            oxmax_q <= oxmax_d;
            oymin_q <= oymin_d;
            oymax_q <= oymax_d;
            uvld_q  <= uvld_d;
            uxmin_q <= uxmin_d;
            uxmax_q <= uxmax_d;
            uymin_q <= uymin_d;
            uymax_q <= uymax_d;
        end
    end

    assign bus.frame_done = done_q;
    assign bus.zone_valid = vld_q;
    assign bus.all_valid  = uvld_q;
    assign bus.all_xmin   = uxmin_q;
    assign bus.all_xmax   = uxmax_q;
    assign bus.all_ymin   = uymin_q;
    assign bus.all_ymax   = uymax_q;

    for (genvar k = 0; k < N_ZONES; k++) begin : g_out
        assign bus.zone_xmin[k*XW +: XW]  = oxmin_q[k];
        assign bus.zone_xmax[k*XW +: XW]  = oxmax_q[k];
        assign bus.zone_ymin[k*YW +: YW]  = oymin_q[k];
        assign bus.zone_ymax[k*YW +: YW]  = oymax_q[k];
        assign bus.zone_count[k*CW +: CW] = ocnt_q[k];
    end
endmodule

// File: tb/tb_motion_zone_bbox.sv
// Bench for motion_zone_bbox: three instances share one pixel stream and differ
// in MIN_PIXELS / CW; results are compared against a frame-level reference model.
module tb_motion_zone_bbox;
    localparam int H = 42, V = 12, NZ = 4, XW = 6, YW = 4, ZW = H / NZ;
    localparam int MAXL = 24, MAXP = 50;

    logic clk = 1'b0, rst_n = 1'b0;
    logic vs = 1'b0, hr = 1'b0, ce = 1'b0, bt = 1'b0;
    int   checks = 0, errors = 0;

    bit   mask [MAXL][MAXP];
    int   cur_nlines, cur_llen;
    int   m_cnt [NZ], m_xmin [NZ], m_xmax [NZ], m_ymin [NZ], m_ymax [NZ];
    int   done_seen;

    always #5 clk = ~clk;

    motion_zone_bbox_if #(.N_ZONES(NZ), .XW(XW), .YW(YW), .CW(16)) ifa ();
    motion_zone_bbox_if #(.N_ZONES(NZ), .XW(XW), .YW(YW), .CW(16)) ifb ();
    motion_zone_bbox_if #(.N_ZONES(NZ), .XW(XW), .YW(YW), .CW(4))  ifc ();

    assign ifa.per_frame_vsync = vs; assign ifa.per_frame_href = hr;
    assign ifa.per_frame_clken = ce; assign ifa.per_img_bit    = bt;
    assign ifb.per_frame_vsync = vs; assign ifb.per_frame_href = hr;
    assign ifb.per_frame_clken = ce; assign ifb.per_img_bit    = bt;
    assign ifc.per_frame_vsync = vs; assign ifc.per_frame_href = hr;
    assign ifc.per_frame_clken = ce; assign ifc.per_img_bit    = bt;

    motion_zone_bbox #(.IMG_HDISP(H), .IMG_VDISP(V), .N_ZONES(NZ), .XW(XW), .YW(YW),
                       .CW(16), .MIN_PIXELS(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    motion_zone_bbox #(.IMG_HDISP(H), .IMG_VDISP(V), .N_ZONES(NZ), .XW(XW), .YW(YW),
                       .CW(16), .MIN_PIXELS(1))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    motion_zone_bbox #(.IMG_HDISP(H), .IMG_VDISP(V), .N_ZONES(NZ), .XW(XW), .YW(YW),
                       .CW(4),  .MIN_PIXELS(2))  dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    typedef struct {
        int x0, y0, x1, y1;
        logic [3:0] vld;
        int axmin, axmax, aymin, aymax;
    } vec_t;
    vec_t tbl [6];

    task automatic cmp(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mask();
        for (int l = 0; l < MAXL; l++)
            for (int p = 0; p < MAXP; p++) mask[l][p] = 1'b0;
    endtask

    // Reference: walk the in-bounds part of the frame and bin by x / ZONE_W.
    task automatic compute_model();
        int z;
        for (int k = 0; k < NZ; k++) begin
            m_cnt[k] = 0; m_xmin[k] = 0; m_xmax[k] = 0; m_ymin[k] = 0; m_ymax[k] = 0;
        end
        for (int l = 0; l < cur_nlines && l < V; l++)
            for (int p = 0; p < cur_llen && p < H; p++)
                if (mask[l][p]) begin
                    z = p / ZW;
                    if (z > NZ - 1) z = NZ - 1;
                    if (m_cnt[z] == 0) begin
                        m_xmin[z] = p; m_xmax[z] = p; m_ymin[z] = l; m_ymax[z] = l;
                    end else begin
                        if (p < m_xmin[z]) m_xmin[z] = p;
                        if (p > m_xmax[z]) m_xmax[z] = p;
                        if (l < m_ymin[z]) m_ymin[z] = l;
                        if (l > m_ymax[z]) m_ymax[z] = l;
                    end
                    m_cnt[z]++;
                end
    endtask

    task automatic check_inst(input string tag, input int minp, input int cw,
                              input logic [3:0] vld, input logic [63:0] zxmin, input logic [63:0] zxmax,
                              input logic [63:0] zymin, input logic [63:0] zymax, input logic [63:0] zcnt,
                              input logic avld, input logic [63:0] axmin, input logic [63:0] axmax,
                              input logic [63:0] aymin, input logic [63:0] aymax);
        longint smax, c, xm, ym;
        bit v, any;
        int ux0, ux1, uy0, uy1;
        smax = (64'd1 << cw) - 1;
        xm = (64'd1 << XW) - 1;
        ym = (64'd1 << YW) - 1;
        any = 0; ux0 = 0; ux1 = 0; uy0 = 0; uy1 = 0;
        for (int k = 0; k < NZ; k++) begin
            c = (m_cnt[k] > smax) ? smax : longint'(m_cnt[k]);
            v = (c >= minp);
            cmp($sformatf("%s z%0d valid", tag, k), longint'(vld[k]), longint'(v));
            cmp($sformatf("%s z%0d count", tag, k), longint'((zcnt >> (k*cw)) & smax), c);
            cmp($sformatf("%s z%0d xmin", tag, k), longint'((zxmin >> (k*XW)) & xm), v ? m_xmin[k] : 0);
            cmp($sformatf("%s z%0d xmax", tag, k), longint'((zxmax >> (k*XW)) & xm), v ? m_xmax[k] : 0);
            cmp($sformatf("%s z%0d ymin", tag, k), longint'((zymin >> (k*YW)) & ym), v ? m_ymin[k] : 0);
            cmp($sformatf("%s z%0d ymax", tag, k), longint'((zymax >> (k*YW)) & ym), v ? m_ymax[k] : 0);
            if (v) begin
                if (!any || m_xmin[k] < ux0) ux0 = m_xmin[k];
                if (!any || m_xmax[k] > ux1) ux1 = m_xmax[k];
                if (!any || m_ymin[k] < uy0) uy0 = m_ymin[k];
                if (!any || m_ymax[k] > uy1) uy1 = m_ymax[k];
                any = 1;
            end
        end
        cmp({tag, " all_valid"}, longint'(avld), longint'(any));
        cmp({tag, " all_xmin"}, longint'(axmin), ux0);
        cmp({tag, " all_xmax"}, longint'(axmax), ux1);
        cmp({tag, " all_ymin"}, longint'(aymin), uy0);
        cmp({tag, " all_ymax"}, longint'(aymax), uy1);
    endtask

    task automatic check_models();
        compute_model();
        check_inst("A", 16, 16, ifa.zone_valid, ifa.zone_xmin, ifa.zone_xmax, ifa.zone_ymin, ifa.zone_ymax,
                   ifa.zone_count, ifa.all_valid, ifa.all_xmin, ifa.all_xmax, ifa.all_ymin, ifa.all_ymax);
        check_inst("B", 1, 16, ifb.zone_valid, ifb.zone_xmin, ifb.zone_xmax, ifb.zone_ymin, ifb.zone_ymax,
                   ifb.zone_count, ifb.all_valid, ifb.all_xmin, ifb.all_xmax, ifb.all_ymin, ifb.all_ymax);
        check_inst("C", 2, 4, ifc.zone_valid, ifc.zone_xmin, ifc.zone_xmax, ifc.zone_ymin, ifc.zone_ymax,
                   ifc.zone_count, ifc.all_valid, ifc.all_xmin, ifc.all_xmax, ifc.all_ymin, ifc.all_ymax);
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, " A frame_done"}, longint'(ifa.frame_done), 0);
        cmp({tag, " A zone_valid"}, longint'(ifa.zone_valid), 0);
        cmp({tag, " A zone_count"}, longint'(ifa.zone_count), 0);
        cmp({tag, " A all_valid"},  longint'(ifa.all_valid), 0);
        cmp({tag, " B zone_xmax"},  longint'(ifb.zone_xmax), 0);
        cmp({tag, " B zone_count"}, longint'(ifb.zone_count), 0);
        cmp({tag, " B all_xmax"},   longint'(ifb.all_xmax), 0);
        cmp({tag, " B all_ymax"},   longint'(ifb.all_ymax), 0);
        cmp({tag, " C zone_count"}, longint'(ifc.zone_count), 0);
    endtask

    // Lines with random clken gaps; bit is randomised on idle cycles to show it is ignored.
    task automatic run_lines(input int l0, input int l1);
        for (int l = l0; l < l1; l++) begin
            for (int p = 0; p < cur_llen; p++) begin
                for (int g = 0; g < 3 && $urandom_range(0, 3) == 0; g++) begin
                    @(negedge clk); hr = 1'b1; ce = 1'b0; bt = 1'($urandom_range(0, 1));
                end
                @(negedge clk); hr = 1'b1; ce = 1'b1; bt = mask[l][p];
            end
            @(negedge clk); hr = 1'b0; ce = 1'b0; bt = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    // vsync pulse with a set pixel on its first cycle; frame_done must pulse once (or never).
    task automatic do_vsync(input string tag, input bit expect_done);
        @(negedge clk); vs = 1'b1; hr = 1'b1; ce = 1'b1; bt = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            hr = 1'b0; ce = 1'b0; bt = 1'b0;
            if (ifa.frame_done) done_seen++;
        end
        vs = 1'b0;
        repeat (3) @(negedge clk);
        cmp({tag, " frame_done pulses"}, done_seen, expect_done ? 1 : 0);
    endtask

    task automatic frame(input string tag, input int nl, input int ll, input bit expect_done);
        cur_nlines = nl; cur_llen = ll;
        run_lines(0, nl);
        do_vsync(tag, expect_done);
        if (expect_done) check_models();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{10, 5, 12, 7, 4'b0010, 10, 12, 5, 7};
        tbl[1] = '{ 9, 3, 10, 3, 4'b0011,  9, 10, 3, 3};
        tbl[2] = '{ 0, 0, 41, 11, 4'b1001, 0, 41, 0, 11};
        tbl[3] = '{35, 2, 30, 9, 4'b1000, 30, 35, 2, 9};
        tbl[4] = '{29, 4, 30, 4, 4'b1100, 29, 30, 4, 4};
        tbl[5] = '{45, 3,  5, 20, 4'b0000, 0, 0, 0, 0};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // full frame straight after reset is discarded; the next one reports
        for (int l = 0; l < MAXL; l++) for (int p = 0; p < MAXP; p++) mask[l][p] = 1'b1;
        frame("first", V, H, 1'b0);
        check_zero("after first");
        frame("full", V, H, 1'b1);
        cmp("full A zone_valid", ifa.zone_valid, 4'hF);
        cmp("full B all_xmax", ifb.all_xmax, H - 1);
        cmp("full B all_ymax", ifb.all_ymax, V - 1);
        cmp("full C z0 count", ifc.zone_count[3:0], 15);

        // directed two-pixel frames on long lines and surplus lines
        for (int i = 0; i < 6; i++) begin
            clear_mask();
            mask[tbl[i].y0][tbl[i].x0] = 1'b1;
            mask[tbl[i].y1][tbl[i].x1] = 1'b1;
            frame($sformatf("vec%0d", i), 22, 48, 1'b1);
            cmp($sformatf("vec%0d B zone_valid", i), ifb.zone_valid, tbl[i].vld);
            cmp($sformatf("vec%0d B all_xmin", i), ifb.all_xmin, tbl[i].axmin);
            cmp($sformatf("vec%0d B all_xmax", i), ifb.all_xmax, tbl[i].axmax);
            cmp($sformatf("vec%0d B all_ymin", i), ifb.all_ymin, tbl[i].aymin);
            cmp($sformatf("vec%0d B all_ymax", i), ifb.all_ymax, tbl[i].aymax);
        end

        // 15 pixels in zone2 fall one short of MIN_PIXELS=16
        clear_mask();
        for (int l = 0; l < 3; l++) for (int p = 20; p < 25; p++) mask[l][p] = 1'b1;
        mask[5][3] = 1'b1;
        frame("z2_15", V, H, 1'b1);
        cmp("z2_15 A valid2", ifa.zone_valid[2], 0);
        cmp("z2_15 A count2", ifa.zone_count[47:32], 15);
        cmp("z2_15 A xmax2", ifa.zone_xmax[17:12], 0);
        cmp("z2_15 B all_xmin", ifb.all_xmin, 3);

        // 20 pixels in zone0 saturate a 4-bit count; pixel beyond the line end ignored
        clear_mask();
        for (int l = 0; l < 2; l++) for (int p = 0; p < 10; p++) mask[l][p] = 1'b1;
        mask[1][45] = 1'b1;
        frame("sat", V, 48, 1'b1);
        cmp("sat C count0", ifc.zone_count[3:0], 15);
        cmp("sat B count0", ifb.zone_count[15:0], 20);
        cmp("sat B all_xmax", ifb.all_xmax, 9);

        // random frames
        for (int f = 0; f < 6; f++) begin
            int dens;
            dens = $urandom_range(1, 30);
            for (int l = 0; l < MAXL; l++)
                for (int p = 0; p < MAXP; p++) mask[l][p] = ($urandom_range(0, 99) < dens);
            frame($sformatf("rnd%0d", f), $urandom_range(V, V + 2), $urandom_range(H, H + 6), 1'b1);
        end

        // reset mid-frame: immediate clear, next boundary only re-arms
        cur_nlines = V; cur_llen = H;
        run_lines(0, 5);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk); rst_n = 1'b1;
        run_lines(5, V);
        do_vsync("post_rst", 1'b0);
        for (int l = 0; l < MAXL; l++)
            for (int p = 0; p < MAXP; p++) mask[l][p] = ($urandom_range(0, 99) < 20);
        frame("recover", V, H, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
